inst_fetch_unit: RTL and testbench

- Instruction fetch front end of the tinyriscv core.
- Owns the PC and issues word requests to instruction memory (1-cycle read latency).
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Redirects on jump/branch from execute, flushing buffered and in-flight fetches.

---
 rtl/inst_fetch_unit.sv | 131 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: owns the PC, requests words from instruction memory, and queues them for decode.
// Latency: grant -> inst_valid_o is 2 cycles (1-cycle memory read, then a registered FIFO head).
// Backpressure: requests stop when buffered plus in-flight words reach DEPTH; jump_flag_i flushes everything.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_ready_i
);

    localparam int          PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CNT_W   = PTR_W + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic             inflight_q, inflight_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]      mem_addr_q [DEPTH];
    logic [31:0]      mem_addr_d [DEPTH];
    logic [31:0]      mem_inst_q [DEPTH];
    logic [31:0]      mem_inst_d [DEPTH];

    logic [CNT_W:0]   occupancy;
    logic             grant;
    logic             push;
    logic             pop;

    // Credit check, handshakes and FIFO head outputs.
    always_comb begin
        occupancy    = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        imem_req_o   = !rst && !jump_flag_i && (occupancy < (CNT_W + 1)'(DEPTH));
        imem_addr_o  = pc_q;
        grant        = imem_req_o && imem_gnt_i;
        // A response arriving in a redirect cycle belongs to the old stream, so it is dropped here.
        push         = inflight_q && imem_rvalid_i && !discard_q && !jump_flag_i;
        inst_valid_o = (count_q != '0);
        pop          = inst_valid_o && inst_ready_i && !jump_flag_i;
        inst_o       = inst_valid_o ? mem_inst_q[rd_ptr_q] : NOP;
        inst_addr_o  = inst_valid_o ? mem_addr_q[rd_ptr_q] : 32'h0000_0000;
    end

    // Next-state for PC, in-flight tracking and FIFO bookkeeping; redirect overrides everything.
    always_comb begin
        pc_d         = pc_q;
        fetch_addr_d = grant ? pc_q : fetch_addr_q;
        inflight_d   = grant;
        discard_d    = discard_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        mem_addr_d   = mem_addr_q;
        mem_inst_d   = mem_inst_q;
        if (jump_flag_i) begin
            pc_d     = jump_addr_i & 32'hFFFF_FFFC;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            // Read latency is exactly one cycle, so an in-flight response normally lands in this
            // very cycle and is killed by the push gate; only a late one needs the discard flag.
            discard_d = inflight_q && !imem_rvalid_i;
        end else begin
            if (grant) begin
                pc_d = pc_q + 32'd4;
            end
            if (inflight_q && imem_rvalid_i && discard_q) begin
                discard_d = 1'b0;
            end
            if (push) begin
                mem_addr_d[wr_ptr_q] = fetch_addr_q;
                mem_inst_d[wr_ptr_q] = imem_rdata_i;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= PC_INIT;
            fetch_addr_q <= 32'h0000_0000;
            inflight_q   <= 1'b0;
            discard_q    <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            pc_q         <= pc_d;
            fetch_addr_q <= fetch_addr_d;
            inflight_q   <= inflight_d;
            discard_q    <= discard_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only observed through count_q, so no reset is needed.
    always_ff @(posedge clk) begin
        mem_addr_q <= mem_addr_d;
        mem_inst_q <= mem_inst_d;
    end

    // Credit accounting must make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (rst) !(push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        inst_ready_i = 1'b0;
    logic        imem_req_o, inst_valid_o;
    logic [31:0] imem_addr_o, inst_o, inst_addr_o;
    logic        hi_req, hi_valid;
    logic [31:0] hi_addr, hi_inst, hi_inst_addr;

    inst_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
        .inst_ready_i(inst_ready_i)
    );

    // Second instance only checks the RESET_PC parameter at reset release.
    inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut_hi (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .imem_req_o(hi_req), .imem_addr_o(hi_addr), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(hi_valid), .inst_o(hi_inst), .inst_addr_o(hi_inst_addr),
        .inst_ready_i(inst_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    int          total = 0;
    int          bad = 0;
    ent_t        fifo_m[$];
    logic        infl;
    ent_t        pend;
    logic [31:0] exp_pc;
    logic        gnt_last;
    logic [31:0] gnt_addr_last;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Assert reset mid-cycle, check outputs immediately, release just after a rising edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        imem_gnt_i = 1'b0; inst_ready_i = 1'b0; jump_flag_i = 1'b0; imem_rvalid_i = 1'b0;
        #1;
        chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_inst", inst_o, NOP);
        chk("rst_iaddr", inst_addr_o, 32'd0);
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_pc", imem_addr_o, 32'd0);
        fifo_m.delete();
        infl = 1'b0;
        exp_pc = 32'd0;
        // A stale response is replayed right after release; the DUT must ignore it.
        gnt_last = 1'b1;
        gnt_addr_last = 32'h0000_BAD0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("hi_rst_req", {31'b0, hi_req}, 32'd1);
        chk("hi_rst_pc", hi_addr, 32'hFFFF_FFF8);
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic step(input logic g, input logic r, input logic j, input logic [31:0] ja);
        logic exp_req;
        logic pop;
        ent_t head;
        @(negedge clk);
        imem_gnt_i = g; inst_ready_i = r; jump_flag_i = j; jump_addr_i = ja;
        imem_rvalid_i = gnt_last;
        imem_rdata_i = gnt_last ? mdata(gnt_addr_last) : 32'hDEAD_BEEF;
        #1;
        exp_req = !j && ((fifo_m.size() + int'(infl)) < DEPTH);
        chk("req", {31'b0, imem_req_o}, {31'b0, exp_req});
        if (imem_req_o) chk("req_addr", imem_addr_o, exp_pc);
        chk("valid", {31'b0, inst_valid_o}, {31'b0, fifo_m.size() != 0});
        if (fifo_m.size() != 0) begin
            head = fifo_m[0];
            chk("head_addr", inst_addr_o, head.a);
            chk("head_inst", inst_o, head.d);
        end else begin
            chk("empty_inst", inst_o, NOP);
            chk("empty_addr", inst_addr_o, 32'd0);
        end
        pop = inst_valid_o && r;
        gnt_last = imem_req_o && g;
        gnt_addr_last = imem_addr_o;
        if (j) begin
            fifo_m.delete();
            infl = 1'b0;
            exp_pc = ja & 32'hFFFF_FFFC;
        end else begin
            if (pop && fifo_m.size() != 0) void'(fifo_m.pop_front());
            if (infl) fifo_m.push_back(pend);
            infl = imem_req_o && g;
            if (infl) begin
                pend.a = exp_pc;
                pend.d = mdata(exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    initial begin
        infl = 1'b0;
        exp_pc = 32'd0;
        gnt_last = 1'b0;
        gnt_addr_last = 32'd0;

        // Streaming with grant and ready held high.
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Decode stalled from reset: FIFO fills with 0x0, 0x4 then requests stop at pc 0x8.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("full_pc", imem_addr_o, 32'h0000_0008);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Memory withholds grant for three cycles.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Redirect while a response is in flight and the FIFO holds an entry.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        chk("jmp_addr", imem_addr_o, 32'h0000_0100);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Held redirect level, then release.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Asynchronous reset with the FIFO full, then restart.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        chk("pre_rst_valid", {31'b0, inst_valid_o}, 32'd1);
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // PC wrap from the top of the address space.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'd0);

        // Random grant, ready and occasional redirects.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 15) == 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
